seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, CLK100MHZ cycles per digit slot (1 kHz digit rate); legal range 2..2^20.
REQ-002 SHALL have port CLK100MHZ  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port value  input  32  eight hex nibbles; nibble i = value[4i+3:4i] shown on digit i.
REQ-005 SHALL have port digit_en  input  8  per-digit enable; 0 forces that digit dark.
REQ-006 SHALL have port dp_in  input  8  per-digit decimal point request, active-high.
REQ-007 SHALL have port AN  output  8  digit anodes, active-low, at most one low at any time.
REQ-008 SHALL have port SEG  output  7  cathodes {CA,CB,CC,CD,CE,CF,CG} = SEG[6:0], active-low.
REQ-009 SHALL have port DP  output  1  decimal point cathode, active-low.
REQ-010 SHALL have port frame_start  output  1  one-cycle pulse at start of each 8-digit frame.

Function
REQ-011 Prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; tick asserted in the cycle the count equals SCAN_DIV-1.
REQ-012 Digit index idx (3 bits) SHALL advance by 1 on each tick and wrap 7 -> 0.
REQ-013 On the tick where idx wraps 7 -> 0, value, digit_en and dp_in SHALL be captured into snapshot registers; display uses only the snapshot (no tearing within a frame).
REQ-014 frame_start SHALL be high exactly in the cycle after the 7 -> 0 tick, i.e. the first cycle the new snapshot is valid.
REQ-015 AN, SEG, DP SHALL be registered and reflect the new idx one cycle after the tick (latency 1).
REQ-016 For the active digit i with snapshot digit_en[i]=1: AN[i]=0, all other AN bits 1, SEG = active-low hex glyph of nibble i, DP = ~dp_snap[i].
REQ-017 Hex glyphs SHALL match the codebase 7-segment table: 0-9 standard, A, b, C, d, E, F.
REQ-018 For the active digit with snapshot digit_en[i]=0 (or blanked per REQ-024): AN=8'hFF, SEG=7'h7F, DP=1.
REQ-019 Each digit SHALL be lit for exactly SCAN_DIV cycles per frame; frame period = 8*SCAN_DIV cycles.
REQ-020 Input changes outside the capture cycle SHALL have no effect on outputs until the next frame.

Reset
REQ-021 RST high SHALL asynchronously force prescaler=0, idx=0, snapshot registers=0, AN=8'hFF, SEG=7'h7F, DP=1, frame_start=0.
REQ-022 Reset asserted mid-frame SHALL abandon the frame; after release, first tick occurs SCAN_DIV cycles later and the first capture after 8 ticks.
REQ-023 Until the first capture after reset, display SHALL show snapshot zeros (all digits dark, digit_en_snap=0).

Configuration
REQ-024 With LEADING_ZERO_BLANK_EN defined, enabled digits above the highest nonzero nibble of the snapshot SHALL be dark; digit 0 SHALL never be blanked by this rule (value 0 shows a single "0").
REQ-025 Without LEADING_ZERO_BLANK_EN, every enabled digit SHALL display its nibble including leading zeros; no blanking logic SHALL be synthesized.

Verification (SCAN_DIV=4 unless stated)
REQ-026 Reset then run 40 cycles with value=32'h0123_4567, digit_en=8'hFF, dp_in=0 -> first frame_start at cycle 33 after release; then AN steps FE,FD,..,7F every 4 cycles, SEG digit0 = glyph 7 (7'b0001111).
REQ-027 value=32'h89AB_CDEF, dp_in=8'h01 -> digit 0 SEG = glyph F (7'b0111000), DP=0 only while AN=8'hFE; digit 7 shows glyph 8 (7'b0000000).
REQ-028 digit_en=8'h0F -> AN never drives bits 7..4 low; those slots show AN=8'hFF, SEG=7'h7F for 4 cycles each.
REQ-029 Change value mid-frame from 32'h1111_1111 to 32'h2222_2222 -> remaining digits of current frame still glyph 1; glyph 2 appears only after next frame_start.
REQ-030 Assert RST for 1 cycle while idx=5 -> AN=8'hFF immediately (same cycle, asynchronous), idx restarts at 0, frame_start 33 cycles after release.
REQ-031 With LEADING_ZERO_BLANK_EN, value=32'h0000_00A0 -> digits 7..2 dark, digit1 = A, digit0 = 0; value=0 -> only digit0 lit with "0"; without macro value=0 lights all eight digits with "0".

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundles the display-side signals of seg7_scan_driver.
//   value[31:0]    eight hex nibbles, nibble i shown on digit i
//   digit_en[7:0]  per-digit enable (0 = dark)
//   dp_in[7:0]     per-digit decimal point request, active-high
//   AN[7:0]        digit anodes, active-low
//   SEG[6:0]       cathodes {CA,CB,CC,CD,CE,CF,CG}, active-low
//   DP             decimal point cathode, active-low
//   frame_start    one-cycle pulse when a new snapshot becomes visible
// master: the side that supplies the data (system / testbench)
// slave : the driver itself
// ---------------------------------------------------------------------------
interface seg7_scan_driver_if;
  logic [31:0] value;
  logic [7:0]  digit_en;
  logic [7:0]  dp_in;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        frame_start;

  modport master (
    output value, digit_en, dp_in,
    input  AN, SEG, DP, frame_start
  );

  modport slave (
    input  value, digit_en, dp_in,
    output AN, SEG, DP, frame_start
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// A prescaler produces one tick every SCAN_DIV clocks; each tick advances
// the active digit. When the digit index wraps 7 -> 0 the inputs are
// captured into a snapshot, so a whole frame is drawn from one coherent
// value (no tearing).
//
// Ports:
//   CLK100MHZ  sole clock, rising edge
//   RST        asynchronous, active-high reset
//   bus        seg7_scan_driver_if.slave (value, digit_en, dp_in in;
//              AN, SEG, DP, frame_start out)
// Parameters:
//   SCAN_DIV   clocks per digit slot, 2..2^20
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, enabled digits above the highest
//                          nonzero nibble are dark (digit 0 always shown)
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic CLK100MHZ,
  input  logic RST,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  // Active-low glyphs, bit order {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Index of the most significant nonzero nibble; 0 when the value is 0,
  // which keeps digit 0 lit for a zero value.
  function automatic logic [2:0] top_nibble(input logic [31:0] v);
    logic [2:0] top;
    top = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (v[4*i +: 4] != 4'h0) top = 3'(i);
    end
    return top;
  endfunction
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      val_snap_q, val_snap_d;
  logic [7:0]       en_snap_q, en_snap_d;
  logic [7:0]       dp_snap_q, dp_snap_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dpo_q, dpo_d;
  logic             fs_q, fs_d;
  logic             tick, wrap;
  logic [3:0]       nib;
  logic             lit;

  assign tick = (cnt_q == CNT_MAX);
  assign wrap = tick && (idx_q == 3'd7);

  // Scan control: prescaler, digit index and frame snapshot.
  always_comb begin
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    idx_d      = tick ? idx_q + 3'd1 : idx_q;
    val_snap_d = wrap ? bus.value    : val_snap_q;
    en_snap_d  = wrap ? bus.digit_en : en_snap_q;
    dp_snap_d  = wrap ? bus.dp_in    : dp_snap_q;
    fs_d       = wrap;
  end

  // Output decode works on next-state index/snapshot so the registered
  // outputs change on the same edge as idx (one cycle after the tick).
  always_comb begin
    nib = val_snap_d[{idx_d, 2'b00} +: 4];
    lit = en_snap_d[idx_d];
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_d > top_nibble(val_snap_d)) lit = 1'b0;
`endif
    an_d  = lit ? ~(8'b1 << idx_d) : 8'hFF;
    seg_d = lit ? hex_glyph(nib)   : 7'h7F;
    dpo_d = lit ? ~dp_snap_d[idx_d] : 1'b1;
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      val_snap_q <= 32'h0;
      en_snap_q  <= 8'h00;
      dp_snap_q  <= 8'h00;
      an_q       <= 8'hFF;
      seg_q      <= 7'h7F;
      dpo_q      <= 1'b1;
      fs_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      val_snap_q <= val_snap_d;
      en_snap_q  <= en_snap_d;
      dp_snap_q  <= dp_snap_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dpo_q      <= dpo_d;
      fs_q       <= fs_d;
    end
  end

  assign bus.AN          = an_q;
  assign bus.SEG         = seg_q;
  assign bus.DP          = dpo_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
// Bench for seg7_scan_driver with SCAN_DIV=4. A cycle-count based model
// predicts AN/SEG/DP/frame_start after every rising edge; directed scenarios
// pin specific values, then a randomized phase stresses the snapshot rule.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int SD    = 4;
  localparam int FRAME = 8 * SD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.SCAN_DIV(SD)) dut (
    .CLK100MHZ (clk),
    .RST       (rst),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  // Lit segments (active-high, {a..g}) for hex digits 0..F.
  logic [6:0] lit_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Model: n = rising edges since reset release; snapshot taken every FRAME edges.
  int          n_q;
  logic [31:0] mv;
  logic [7:0]  me, md;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q <= 0;
      mv  <= 32'h0;
      me  <= 8'h00;
      md  <= 8'h00;
    end else begin
      n_q <= n_q + 1;
      if ((n_q + 1) % FRAME == 0) begin
        mv <= bus.value;
        me <= bus.digit_en;
        md <= bus.dp_in;
      end
    end
  end

  function automatic void exp_out(input int n, input logic [31:0] v, input logic [7:0] e,
                                  input logic [7:0] d, output logic [7:0] an,
                                  output logic [6:0] seg, output logic dp, output logic fs);
    int  slot;
    int  top;
    bit  on;
    slot = (n / SD) % 8;
    fs   = (n > 0) && (n % FRAME == 0);
    on   = e[slot];
`ifdef LEADING_ZERO_BLANK_EN
    top = 0;
    for (int i = 1; i < 8; i++) if ((v >> (4 * i)) != 0) top = i;
    if (slot > top) on = 1'b0;
`else
    top = 0;
`endif
    if (on) begin
      an  = 8'hFF ^ (8'h01 << slot);
      seg = ~lit_tbl[(v >> (4 * slot)) & 32'hF];
      dp  = ~d[slot];
    end else begin
      an  = 8'hFF;
      seg = 7'h7F;
      dp  = 1'b1;
    end
  endfunction

  logic [7:0] ean;
  logic [6:0] eseg;
  logic       edp, efs;

  always @(negedge clk) begin
    if (cmp_on && !rst) begin
      exp_out(n_q, mv, me, md, ean, eseg, edp, efs);
      checks++;
      if ({bus.AN, bus.SEG, bus.DP, bus.frame_start} !== {ean, eseg, edp, efs}) begin
        errors++;
        $display("FAIL model n=%0d got AN=%h SEG=%b DP=%b FS=%b want AN=%h SEG=%b DP=%b FS=%b",
                 n_q, bus.AN, bus.SEG, bus.DP, bus.frame_start, ean, eseg, edp, efs);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Returns at the negedge where frame_start is high; edges = negedges waited.
  task automatic wait_fs(output int edges);
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (bus.frame_start !== 1'b1 && edges < 3 * FRAME);
    if (bus.frame_start !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL fs_timeout got no frame_start within %0d cycles", edges);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  logic [7:0] an_seq [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  initial begin
    int e;
    bus.value    = 32'h0123_4567;
    bus.digit_en = 8'hFF;
    bus.dp_in    = 8'h00;
    step(3);
    chk("rst_an",  32'(bus.AN),  32'hFF);
    chk("rst_seg", 32'(bus.SEG), 32'h7F);
    chk("rst_dp",  32'(bus.DP),  32'h1);
    chk("rst_fs",  32'(bus.frame_start), 32'h0);
    rst    = 1'b0;
    cmp_on = 1'b1;

    // First frame: 32 edges after release (cycle 33 counting the release cycle as 1).
    wait_fs(e);
    chk("first_fs_edges", 32'(e), 32'd32);
    for (int k = 0; k < 8; k++) begin
      chk("scan_an", 32'(bus.AN), 32'(an_seq[k]));
      if (k == 0) chk("seg_digit0_7", 32'(bus.SEG), 32'(7'b0001111));
      step(SD);
    end

    // Glyph F / 8 and decimal point on digit 0 only.
    bus.value = 32'h89AB_CDEF;
    bus.dp_in = 8'h01;
    wait_fs(e);
    chk("d0_an",  32'(bus.AN),  32'hFE);
    chk("d0_segF", 32'(bus.SEG), 32'(7'b0111000));
    chk("d0_dp",  32'(bus.DP),  32'h0);
    step(SD);
    chk("d1_dp",  32'(bus.DP),  32'h1);
    step(6 * SD);
    chk("d7_an",  32'(bus.AN),  32'h7F);
    chk("d7_seg8", 32'(bus.SEG), 32'(7'b0000000));

    // Upper four digits disabled.
    bus.value    = $urandom;
    bus.dp_in    = 8'hF0;
    bus.digit_en = 8'h0F;
    wait_fs(e);
    step(4 * SD);
    chk("en_d4_an",  32'(bus.AN),  32'hFF);
    chk("en_d4_seg", 32'(bus.SEG), 32'h7F);
    step(3 * SD);
    chk("en_d7_an",  32'(bus.AN),  32'hFF);

    // Mid-frame change stays invisible until the next frame.
    bus.digit_en = 8'hFF;
    bus.dp_in    = 8'h00;
    bus.value    = 32'h1111_1111;
    wait_fs(e);
    step(2 * SD);
    bus.value = 32'h2222_2222;
    step(3 * SD);
    chk("tear_d5_an",  32'(bus.AN),  32'hDF);
    chk("tear_d5_seg", 32'(bus.SEG), 32'(7'b1001111));
    wait_fs(e);
    chk("new_d0_seg2", 32'(bus.SEG), 32'(7'b0010010));

    // Asynchronous reset while digit 5 is active.
    step(5 * SD);
    chk("pre_rst_an", 32'(bus.AN), 32'hDF);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_an",  32'(bus.AN),  32'hFF);
    chk("async_rst_seg", 32'(bus.SEG), 32'h7F);
    chk("async_rst_dp",  32'(bus.DP),  32'h1);
    @(negedge clk);
    rst = 1'b0;
    wait_fs(e);
    chk("rerst_fs_edges", 32'(e), 32'd32);
    chk("rerst_d0_an", 32'(bus.AN), 32'hFE);

    // Leading-zero handling.
    bus.value = 32'h0000_00A0;
    wait_fs(e);
    chk("lz_d0_seg0", 32'(bus.SEG), 32'(7'b0000001));
    step(SD);
    chk("lz_d1_segA", 32'(bus.SEG), 32'(7'b0001000));
    step(SD);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_d2_an", 32'(bus.AN), 32'hFF);
`else
    chk("lz_d2_an", 32'(bus.AN), 32'hFB);
`endif
    bus.value = 32'h0;
    wait_fs(e);
    chk("zero_d0_an",  32'(bus.AN),  32'hFE);
    chk("zero_d0_seg", 32'(bus.SEG), 32'(7'b0000001));
    step(3 * SD);
`ifdef LEADING_ZERO_BLANK_EN
    chk("zero_d3_an", 32'(bus.AN), 32'hFF);
`else
    chk("zero_d3_an", 32'(bus.AN), 32'hF7);
`endif

    // Randomized inputs changing at arbitrary cycles.
    repeat (6 * FRAME) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        bus.value    = $urandom >> (4 * $urandom_range(0, 8));
        bus.digit_en = 8'($urandom);
        bus.dp_in    = 8'($urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
